// File: rtl/mseq_pkg.sv
// Shared definitions for the micro-sequencer: SEQ opcodes and control-word field layout.
package mseq_pkg;

   localparam logic [1:0] SEQ_JUMP   = 2'b00;
   localparam logic [1:0] SEQ_DECODE = 2'b01;
   localparam logic [1:0] SEQ_CALL   = 2'b10;
   localparam logic [1:0] SEQ_RET    = 2'b11;

   function automatic int csel_w(input int ncond);
      return $clog2(ncond + 1);
   endfunction

   function automatic int csel_lo();
      return 2;
   endfunction

   function automatic int j_lo(input int ncond);
      return csel_lo() + csel_w(ncond);
   endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Sequencer bus: stall, decode/condition inputs, control-store write port and status outputs.
// MSEQ_BREAKPOINT_EN adds the breakpoint signals.
interface micro_sequencer_if #(
   parameter int ADDR_W = 7,
   parameter int WORD_W = 64,
   parameter int FAM_W  = 16,
   parameter int NCOND  = 3
);
   logic              stall;
   logic [FAM_W-1:0]  family_bits;
   logic [NCOND-1:0]  cond;
   logic              cs_we;
   logic [ADDR_W-1:0] cs_waddr;
   logic [WORD_W-1:0] cs_wdata;
   logic [ADDR_W-1:0] upc;
   logic [WORD_W-1:0] cs_word;
   logic              illegal_decode;
   logic              stack_ovf;
   logic              stack_unf;
`ifdef MSEQ_BREAKPOINT_EN
   logic              bp_en;
   logic [ADDR_W-1:0] bp_addr;
   logic              bp_resume;
   logic              halted;

   modport master (
      output stall, family_bits, cond, cs_we, cs_waddr, cs_wdata, bp_en, bp_addr, bp_resume,
      input  upc, cs_word, illegal_decode, stack_ovf, stack_unf, halted
   );
   modport slave (
      input  stall, family_bits, cond, cs_we, cs_waddr, cs_wdata, bp_en, bp_addr, bp_resume,
      output upc, cs_word, illegal_decode, stack_ovf, stack_unf, halted
   );
`else
   modport master (
      output stall, family_bits, cond, cs_we, cs_waddr, cs_wdata,
      input  upc, cs_word, illegal_decode, stack_ovf, stack_unf
   );
   modport slave (
      input  stall, family_bits, cond, cs_we, cs_waddr, cs_wdata,
      output upc, cs_word, illegal_decode, stack_ovf, stack_unf
   );
`endif
endinterface

// File: rtl/mseq_prio_enc.sv
// Lowest-set-bit encoder: idx is the position of the lowest 1, valid is low for an all-zero input.
module mseq_prio_enc #(
   parameter int FAM_W = 16,
   localparam int ENC_W = (FAM_W > 1) ? $clog2(FAM_W) : 1
) (
   input  logic [FAM_W-1:0] bits,
   output logic [ENC_W-1:0] idx,
   output logic             valid
);
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      // Scan downwards so the lowest set bit is the last assignment.
      for (int i = FAM_W - 1; i >= 0; i--) begin
         if (bits[i]) begin
            idx   = ENC_W'(i);
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/micro_sequencer.sv
// Microcode sequencer: control store, micro-PC, jump/decode/call/return next-address logic.
// Optional breakpoint/halt logic is compiled in when MSEQ_BREAKPOINT_EN is defined.
module micro_sequencer
   import mseq_pkg::*;
#(
   parameter int ADDR_W      = 7,
   parameter int WORD_W      = 64,
   parameter int FAM_W       = 16,
   parameter int NCOND       = 3,
   parameter int DEC_SHIFT   = 3,
   parameter int STACK_DEPTH = 4
) (
   input logic              clk,
   input logic              rst,
   micro_sequencer_if.slave bus
);
   localparam int CSEL_W = csel_w(NCOND);
   localparam int J_LO   = j_lo(NCOND);
   localparam int ENC_W  = (FAM_W > 1) ? $clog2(FAM_W) : 1;
   localparam int DEC_W  = ENC_W + DEC_SHIFT;
   localparam int SP_W   = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [WORD_W-1:0] store_mem [2**ADDR_W];
   logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

   logic [ADDR_W-1:0] upc_reg, upc_next;
   logic [SP_W-1:0]   sp_reg, sp_next;
   logic              illegal_reg, illegal_next;
   logic              ovf_reg, ovf_next;
   logic              unf_reg, unf_next;
   logic              push_en;
   logic              advance;

   logic [WORD_W-1:0] cs_word;
   logic [1:0]        seq;
   logic [CSEL_W-1:0] csel;
   logic [ADDR_W-1:0] j_field, cond_mask, tgt, dec_tgt;
   logic [ENC_W-1:0]  fam_idx;
   logic              fam_valid;
   logic [DEC_W-1:0]  dec_full;
   logic [IDX_W-1:0]  push_idx, pop_idx;

   always_ff @(posedge clk) begin
      if (bus.cs_we) store_mem[bus.cs_waddr] <= bus.cs_wdata;
   end

   assign cs_word = store_mem[upc_reg];
   assign seq     = cs_word[1:0];
   assign csel    = cs_word[csel_lo() +: CSEL_W];
   assign j_field = cs_word[J_LO +: ADDR_W];

   // CSEL=k ORs cond[k-1] into target bit k-1; unused selector codes leave J untouched.
   generate
      for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_cond
         if (gi < NCOND) begin : g_used
            assign cond_mask[gi] = (csel == CSEL_W'(gi + 1)) && bus.cond[gi];
         end else begin : g_unused
            assign cond_mask[gi] = 1'b0;
         end
      end
   endgenerate

   assign tgt = j_field | cond_mask;

   mseq_prio_enc #(.FAM_W(FAM_W)) u_prio_enc (
      .bits  (bus.family_bits),
      .idx   (fam_idx),
      .valid (fam_valid)
   );

   assign dec_full = DEC_W'(fam_idx) << DEC_SHIFT;
   assign dec_tgt  = ADDR_W'(dec_full);
   assign push_idx = IDX_W'(sp_reg);
   assign pop_idx  = IDX_W'(sp_reg - SP_W'(1));

   always_comb begin
      upc_next     = upc_reg;
      sp_next      = sp_reg;
      illegal_next = illegal_reg;
      ovf_next     = ovf_reg;
      unf_next     = unf_reg;
      push_en      = 1'b0;
      if (advance) begin
         case (seq)
            SEQ_JUMP: upc_next = tgt;
            SEQ_DECODE: begin
               if (fam_valid) begin
                  upc_next = dec_tgt;
               end else begin
                  upc_next     = '0;
                  illegal_next = 1'b1;
               end
            end
            SEQ_CALL: begin
               upc_next = tgt;
               if (sp_reg == SP_W'(STACK_DEPTH)) begin
                  ovf_next = 1'b1;
               end else begin
                  push_en = 1'b1;
                  sp_next = sp_reg + SP_W'(1);
               end
            end
            default: begin
               if (sp_reg == '0) begin
                  upc_next = '0;
                  unf_next = 1'b1;
               end else begin
                  upc_next = stack_mem[pop_idx];
                  sp_next  = sp_reg - SP_W'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         upc_reg     <= '0;
         sp_reg      <= '0;
         illegal_reg <= 1'b0;
         ovf_reg     <= 1'b0;
         unf_reg     <= 1'b0;
      end else begin
         upc_reg     <= upc_next;
         sp_reg      <= sp_next;
         illegal_reg <= illegal_next;
         ovf_reg     <= ovf_next;
         unf_reg     <= unf_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push_en) stack_mem[push_idx] <= upc_reg + ADDR_W'(1);
   end

`ifdef MSEQ_BREAKPOINT_EN
   logic halted_reg, skip_reg, bp_hit;

   assign advance = !bus.stall && !halted_reg;
   // The first advance after a resume is exempt so the sequencer can leave the breakpoint.
   assign bp_hit  = bus.bp_en && advance && !skip_reg && (upc_next == bus.bp_addr);

   always_ff @(posedge clk) begin
      if (rst) begin
         halted_reg <= 1'b0;
         skip_reg   <= 1'b0;
      end else if (halted_reg && bus.bp_resume) begin
         halted_reg <= 1'b0;
         skip_reg   <= 1'b1;
      end else if (bp_hit) begin
         halted_reg <= 1'b1;
      end else if (advance) begin
         skip_reg   <= 1'b0;
      end
   end

   assign bus.halted = halted_reg;
`else
   assign advance = !bus.stall;
`endif

   assign bus.upc            = upc_reg;
   assign bus.cs_word        = cs_word;
   assign bus.illegal_decode = illegal_reg;
   assign bus.stack_ovf      = ovf_reg;
   assign bus.stack_unf      = unf_reg;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: jump/cond, decode, call/return, stack limits, stall, reset, breakpoint.
module tb_micro_sequencer;
   import mseq_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   micro_sequencer_if #(.ADDR_W(7), .WORD_W(64), .FAM_W(16), .NCOND(3)) bus ();

   micro_sequencer #(
      .ADDR_W(7), .WORD_W(64), .FAM_W(16), .NCOND(3), .DEC_SHIFT(3), .STACK_DEPTH(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Layout for CSEL_W=2, ADDR_W=7: SEQ[1:0], CSEL[3:2], J[10:4].
   function automatic logic [63:0] mw(input logic [1:0] s, input logic [1:0] c, input logic [6:0] j);
      logic [63:0] w;
      w        = '0;
      w[1:0]   = s;
      w[3:2]   = c;
      w[10:4]  = j;
      return w;
   endfunction

   task automatic wr(input logic [6:0] a, input logic [63:0] d);
      bus.cs_we    = 1'b1;
      bus.cs_waddr = a;
      bus.cs_wdata = d;
      tick();
      bus.cs_we    = 1'b0;
   endtask

   task automatic restart();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      bus.stall       = 1'b0;
      bus.family_bits = '0;
      bus.cond        = '0;
      bus.cs_we       = 1'b0;
      bus.cs_waddr    = '0;
      bus.cs_wdata    = '0;
`ifdef MSEQ_BREAKPOINT_EN
      bus.bp_en       = 1'b0;
      bus.bp_addr     = '0;
      bus.bp_resume   = 1'b0;
`endif
      tick();
      tick();
      check_eq("rst_upc", 64'(bus.upc), 64'd0);
      check_eq("rst_illegal", 64'(bus.illegal_decode), 64'd0);
      check_eq("rst_ovf", 64'(bus.stack_ovf), 64'd0);
      check_eq("rst_unf", 64'(bus.stack_unf), 64'd0);

      // Jump with condition OR
      wr(7'd0, mw(SEQ_JUMP, 2'd2, 7'd5));
      wr(7'd5, mw(SEQ_JUMP, 2'd0, 7'd9));
      wr(7'd9, mw(SEQ_JUMP, 2'd0, 7'd9));
      wr(7'd7, mw(SEQ_JUMP, 2'd0, 7'd7));
      wr(7'd12, mw(SEQ_JUMP, 2'd0, 7'd12));
      rst = 1'b0;
      check_eq("jmp_start", 64'(bus.upc), 64'd0);
      tick(); check_eq("jmp_nocond", 64'(bus.upc), 64'd5);
      tick(); check_eq("jmp_chain", 64'(bus.upc), 64'd9);
      wr(7'd9, mw(SEQ_JUMP, 2'd0, 7'd12));
      check_eq("rdw_word", bus.cs_word, mw(SEQ_JUMP, 2'd0, 7'd12));
      check_eq("rdw_upc", 64'(bus.upc), 64'd9);
      tick(); check_eq("rdw_next", 64'(bus.upc), 64'd12);
      bus.cond = 3'b010;
      restart();
      check_eq("cond_start", 64'(bus.upc), 64'd0);
      tick(); check_eq("jmp_cond1", 64'(bus.upc), 64'd7);
      bus.cond = 3'b001;
      restart();
      tick(); check_eq("jmp_cond_other", 64'(bus.upc), 64'd5);
      bus.cond = 3'b000;

      // Family decode
      rst = 1'b1;
      wr(7'd0, mw(SEQ_DECODE, 2'd0, 7'd0));
      wr(7'd32, mw(SEQ_JUMP, 2'd0, 7'd32));
      wr(7'd8, mw(SEQ_JUMP, 2'd0, 7'd8));
      bus.family_bits = 16'h0010;
      rst = 1'b0;
      tick(); check_eq("dec_fam4", 64'(bus.upc), 64'd32);
      bus.family_bits = 16'h0012;
      restart();
      tick(); check_eq("dec_multihot", 64'(bus.upc), 64'd8);
      bus.family_bits = 16'h0000;
      restart();
      tick(); check_eq("dec_zero_upc", 64'(bus.upc), 64'd0);
      check_eq("dec_zero_flag", 64'(bus.illegal_decode), 64'd1);
      tick();
      bus.family_bits = 16'h0010;
      tick(); check_eq("dec_after_ill", 64'(bus.upc), 64'd32);
      check_eq("dec_flag_sticky", 64'(bus.illegal_decode), 64'd1);
      rst = 1'b1;
      tick(); check_eq("dec_flag_rst", 64'(bus.illegal_decode), 64'd0);

      // Call / return
      wr(7'd0, mw(SEQ_JUMP, 2'd0, 7'd3));
      wr(7'd3, mw(SEQ_CALL, 2'd0, 7'd40));
      wr(7'd40, mw(SEQ_RET, 2'd0, 7'd0));
      wr(7'd4, mw(SEQ_RET, 2'd0, 7'd0));
      rst = 1'b0;
      tick(); check_eq("call_at3", 64'(bus.upc), 64'd3);
      tick(); check_eq("call_to40", 64'(bus.upc), 64'd40);
      tick(); check_eq("ret_to4", 64'(bus.upc), 64'd4);
      check_eq("ret_no_unf", 64'(bus.stack_unf), 64'd0);
      tick(); check_eq("ret_empty_upc", 64'(bus.upc), 64'd0);
      check_eq("ret_empty_unf", 64'(bus.stack_unf), 64'd1);

      // Nested calls beyond depth, then unwind to underflow
      rst = 1'b1;
      wr(7'd0, mw(SEQ_CALL, 2'd0, 7'd10));
      wr(7'd10, mw(SEQ_CALL, 2'd0, 7'd20));
      wr(7'd20, mw(SEQ_CALL, 2'd0, 7'd30));
      wr(7'd30, mw(SEQ_CALL, 2'd0, 7'd50));
      wr(7'd50, mw(SEQ_CALL, 2'd0, 7'd60));
      wr(7'd60, mw(SEQ_RET, 2'd0, 7'd0));
      wr(7'd31, mw(SEQ_RET, 2'd0, 7'd0));
      wr(7'd21, mw(SEQ_RET, 2'd0, 7'd0));
      wr(7'd11, mw(SEQ_RET, 2'd0, 7'd0));
      wr(7'd1, mw(SEQ_RET, 2'd0, 7'd0));
      check_eq("nest_rst_unf", 64'(bus.stack_unf), 64'd0);
      rst = 1'b0;
      tick(); check_eq("nest_10", 64'(bus.upc), 64'd10);
      tick(); check_eq("nest_20", 64'(bus.upc), 64'd20);
      tick(); check_eq("nest_30", 64'(bus.upc), 64'd30);
      tick(); check_eq("nest_50", 64'(bus.upc), 64'd50);
      check_eq("nest_no_ovf", 64'(bus.stack_ovf), 64'd0);
      tick(); check_eq("nest_60", 64'(bus.upc), 64'd60);
      check_eq("nest_ovf", 64'(bus.stack_ovf), 64'd1);
      tick(); check_eq("unwind_31", 64'(bus.upc), 64'd31);
      tick(); check_eq("unwind_21", 64'(bus.upc), 64'd21);
      tick(); check_eq("unwind_11", 64'(bus.upc), 64'd11);
      tick(); check_eq("unwind_1", 64'(bus.upc), 64'd1);
      check_eq("unwind_no_unf", 64'(bus.stack_unf), 64'd0);
      tick(); check_eq("unwind_0", 64'(bus.upc), 64'd0);
      check_eq("unwind_unf", 64'(bus.stack_unf), 64'd1);
      rst = 1'b1;
      tick();
      check_eq("flags_clr_ovf", 64'(bus.stack_ovf), 64'd0);
      check_eq("flags_clr_unf", 64'(bus.stack_unf), 64'd0);

      // Stall mid-program, then reset partway through the call chain
      rst = 1'b0;
      tick(); check_eq("stall_pre", 64'(bus.upc), 64'd10);
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); check_eq($sformatf("stall_hold%0d", i), 64'(bus.upc), 64'd10);
      end
      bus.stall = 1'b0;
      tick(); check_eq("stall_resume", 64'(bus.upc), 64'd20);
      tick(); check_eq("chain_30", 64'(bus.upc), 64'd30);
      rst = 1'b1;
      tick(); check_eq("midrst_upc", 64'(bus.upc), 64'd0);
      rst = 1'b0;
      tick(); tick(); tick(); tick();
      check_eq("midrst_50", 64'(bus.upc), 64'd50);
      check_eq("midrst_no_ovf", 64'(bus.stack_ovf), 64'd0);

`ifdef MSEQ_BREAKPOINT_EN
      rst = 1'b1;
      wr(7'd0, mw(SEQ_JUMP, 2'd0, 7'd5));
      wr(7'd5, mw(SEQ_JUMP, 2'd0, 7'd9));
      wr(7'd9, mw(SEQ_JUMP, 2'd0, 7'd5));
      check_eq("bp_rst_halted", 64'(bus.halted), 64'd0);
      bus.bp_en   = 1'b1;
      bus.bp_addr = 7'd5;
      rst = 1'b0;
      tick(); check_eq("bp_hit_upc", 64'(bus.upc), 64'd5);
      check_eq("bp_hit_halted", 64'(bus.halted), 64'd1);
      tick(); check_eq("bp_hold_upc", 64'(bus.upc), 64'd5);
      bus.bp_resume = 1'b1;
      tick();
      bus.bp_resume = 1'b0;
      check_eq("bp_resume_halted", 64'(bus.halted), 64'd0);
      tick(); check_eq("bp_adv_upc", 64'(bus.upc), 64'd9);
      check_eq("bp_adv_halted", 64'(bus.halted), 64'd0);
      tick(); check_eq("bp_rehit_upc", 64'(bus.upc), 64'd5);
      check_eq("bp_rehit_halted", 64'(bus.halted), 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
